unbounce_bb: RTL and testbench

UNBOUNCE_BB -- requirements
Module: unbounce_bb

---
 rtl/unbounce_bb.sv | 59 +++++
 tb/tb_unbounce_bb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/unbounce_bb.sv
// Switch/button debouncer: synchronizes a raw level and accepts a new level only
// after it has been seen for STABLE_COUNT consecutive samples, with edge pulses.
module unbounce_bb #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_COUNT = 8,
  parameter int   CNT_WIDTH    = 4,
  parameter logic RESET_VALUE  = 1'b1
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic iin,
  output logic iout,
  output logic ofall,
  output logic orise
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   s;
  logic                   differs;
  logic                   accept;

  // Synchronizer idles at the button's pulled-up level so reset release looks quiet.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iin};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign differs = (s != iout);
  assign accept  = differs && (cnt == CNT_LAST);

  // Any sample that agrees with the current output discards the partial count.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt   <= '0;
      iout  <= RESET_VALUE;
      ofall <= 1'b0;
      orise <= 1'b0;
    end else begin
      ofall <= accept & ~s;
      orise <= accept & s;
      if (accept) begin
        iout <= s;
        cnt  <= '0;
      end else if (differs) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_unbounce_bb.sv
// Bench for unbounce_bb: two instances (STABLE_COUNT 8 and 1) share one stimulus,
// a window-based reference model fills scoreboards that a negedge monitor drains.
module tb_unbounce_bb;

  localparam int SYNC = 2;
  localparam int NA   = 8;
  localparam int NB   = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic din   = 1'b1;
  logic out_a, fall_a, rise_a;
  logic out_b, fall_b, rise_b;

  int total = 0;
  int bad   = 0;

  logic [7:0]  raw_hist;
  logic [15:0] seen_hist;
  logic        exp_a, exp_b;
  logic [2:0]  q_a[$];
  logic [2:0] q_b[$];

  always #5 clk = ~clk;

  unbounce_bb #(.SYNC_STAGES(SYNC), .STABLE_COUNT(NA), .CNT_WIDTH(4), .RESET_VALUE(1'b1)) dut_a (
    .iclk(clk), .irst_n(rst_n), .iin(din), .iout(out_a), .ofall(fall_a), .orise(rise_a)
  );

  unbounce_bb #(.SYNC_STAGES(SYNC), .STABLE_COUNT(NB), .CNT_WIDTH(4), .RESET_VALUE(1'b1)) dut_b (
    .iclk(clk), .irst_n(rst_n), .iin(din), .iout(out_b), .ofall(fall_b), .orise(rise_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The output flips once the last n synchronized samples all disagree with it.
  function automatic bit window_differs(input int n, input logic lvl);
    for (int i = 0; i < n; i++)
      if (seen_hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    raw_hist  = '1;
    seen_hist = '1;
    exp_a     = 1'b1;
    exp_b     = 1'b1;
  endtask

  task automatic model_edge(input logic v);
    logic seen_val, fa, ra, fb, rb;
    seen_val  = raw_hist[SYNC-1];
    raw_hist  = {raw_hist[6:0], v};
    seen_hist = {seen_hist[14:0], seen_val};
    fa = 1'b0; ra = 1'b0; fb = 1'b0; rb = 1'b0;
    if (window_differs(NA, exp_a)) begin
      exp_a = ~exp_a;
      fa = ~exp_a;
      ra = exp_a;
    end
    if (window_differs(NB, exp_b)) begin
      exp_b = ~exp_b;
      fb = ~exp_b;
      rb = exp_b;
    end
    q_a.push_back({exp_a, fa, ra});
    q_b.push_back({exp_b, fb, rb});
  endtask

  task automatic applyStimulus(input logic v);
    din = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic doReset(input logic level);
    @(negedge clk);
    #1;
    din   = level;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_iout_a", out_a, 1);
    checkOutput("rst_cnt_a", int'(dut_a.cnt), 0);
    checkOutput("rst_fall_a", fall_a, 0);
    checkOutput("rst_rise_a", rise_a, 0);
    checkOutput("rst_iout_b", out_b, 1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      checkOutput("a_iout", out_a, e[2]);
      checkOutput("a_ofall", fall_a, e[1]);
      checkOutput("a_orise", rise_a, e[0]);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checkOutput("b_iout", out_b, e[2]);
      checkOutput("b_ofall", fall_b, e[1]);
      checkOutput("b_orise", rise_b, e[0]);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int first;
    logic lvl;
    logic r;
    int len;

    model_reset();
    doReset(1'b1);
    repeat (20) applyStimulus(1'b1);

    // Falling acceptance latency from the first edge that samples the new level.
    edges = 0;
    do begin
      applyStimulus(1'b0);
      edges++;
    end while (out_a == 1'b1 && edges < 20);
    checkOutput("fall_latency", edges, 10);
    checkOutput("fall_pulse", fall_a, 1);
    repeat (5) applyStimulus(1'b0);

    // Short high glitch must not move the output.
    repeat (5) applyStimulus(1'b1);
    repeat (12) applyStimulus(1'b0);
    checkOutput("glitch_hold", out_a, 0);

    // Bounce toward 0 then hold; latency measured from the final 0.
    repeat (15) applyStimulus(1'b1);
    checkOutput("back_high", out_a, 1);
    applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
    edges = 0;
    do begin
      applyStimulus(1'b0);
      edges++;
    end while (out_a == 1'b1 && edges < 20);
    checkOutput("bounce_latency", edges, 10);
    repeat (5) applyStimulus(1'b0);

    // Reset in the middle of a count.
    repeat (15) applyStimulus(1'b1);
    repeat (7) applyStimulus(1'b0);
    checkOutput("pre_rst_cnt", int'(dut_a.cnt), 7 - SYNC);
    doReset(1'b1);
    repeat (1000) applyStimulus(1'b1);
    checkOutput("idle_iout", out_a, 1);

    // Toggle every 3 cycles; the STABLE_COUNT=1 instance follows 3 edges later.
    lvl = 1'b1;
    for (int t = 0; t < 10; t++) begin
      lvl   = ~lvl;
      first = 0;
      for (int k = 1; k <= 3; k++) begin
        applyStimulus(lvl);
        if (first == 0 && out_b == lvl) first = k;
      end
      checkOutput("b_follow_latency", first, 3);
    end

    // Random runs of random length.
    for (int t = 0; t < 60; t++) begin
      r   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      repeat (len) applyStimulus(r);
    end
    repeat (15) applyStimulus(1'b1);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", q_a.size() + q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
